// File: rtl/cnn_layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_sequencer_if
// Purpose  : Stage-engine handshake bundle between the layer sequencer and
//            the conv / max-pool / fully-connected engines.
// Ports    : (interface, no ports)
//            stage_clear            - clear pulse to all engines
//            conv/pool/fc_enable    - level run enables, sequencer -> engine
//            conv/pool/fc_done      - level done flags, engine -> sequencer
// Modports : master (sequencer side), slave (engine side)
// Revision : 1.0 - initial release
// ============================================================================
interface cnn_layer_sequencer_if;
    logic stage_clear;
    logic conv_enable;
    logic conv_done;
    logic pool_enable;
    logic pool_done;
    logic fc_enable;
    logic fc_done;

    modport master (
        output stage_clear,
        output conv_enable,
        output pool_enable,
        output fc_enable,
        input  conv_done,
        input  pool_done,
        input  fc_done
    );

    modport slave (
        input  stage_clear,
        input  conv_enable,
        input  pool_enable,
        input  fc_enable,
        output conv_done,
        output pool_done,
        output fc_done
    );
endinterface
`default_nettype wire

// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_sequencer
// Purpose  : Per-image scheduler for the CNN forward path. For every image it
//            clears the stage engines, then runs conv, max-pool and FC in
//            turn, each through a level enable / level done handshake. A
//            per-stage watchdog traps hung stages in an error state.
// Ports    : clk         - system clock
//            reset       - asynchronous active-low reset
//            start       - begin a sequence (accepted in IDLE only)
//            abort       - return to IDLE from any state
//            num_images  - image count, latched on accepted start
//            stg         - stage handshake bundle (master side)
//            busy        - high in every state except IDLE
//            image_idx   - index of the image in progress
//            seq_done    - one-cycle pulse when all images complete
//            timeout_err - watchdog error flag (held while in ERR)
//            state_dbg   - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module cnn_layer_sequencer #(
    parameter int NUM_IMAGES_W   = 8,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TMO_W          = 21
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    start,
    input  wire logic                    abort,
    input  wire logic [NUM_IMAGES_W-1:0] num_images,
    cnn_layer_sequencer_if.master        stg,
    output logic                         busy,
    output logic [NUM_IMAGES_W-1:0]      image_idx,
    output logic                         seq_done,
    output logic                         timeout_err,
    output logic [2:0]                   state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_CONV  = 3'd2;
    localparam logic [2:0] S_POOL  = 3'd3;
    localparam logic [2:0] S_FC    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]        TMO_ONE  = TMO_W'(1);
    localparam logic [NUM_IMAGES_W-1:0] IMG_ONE  = NUM_IMAGES_W'(1);

    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic [TMO_W-1:0]        wdog;
    logic [NUM_IMAGES_W-1:0] img_count;

    logic in_stage;
    logic stage_done;
    logic wdog_expired;
    logic last_image;

    // Next-cycle values of the registered Moore outputs.
    logic nxt_clear;
    logic nxt_conv;
    logic nxt_pool;
    logic nxt_fc;
    logic nxt_busy;
    logic nxt_done;
    logic nxt_err;

    // Only the done flag belonging to the current stage is ever looked at,
    // so sticky or early done flags from other engines are harmless.
    always_comb begin
        in_stage   = 1'b0;
        stage_done = 1'b0;
        case (state)
            S_CONV: begin in_stage = 1'b1; stage_done = stg.conv_done; end
            S_POOL: begin in_stage = 1'b1; stage_done = stg.pool_done; end
            S_FC:   begin in_stage = 1'b1; stage_done = stg.fc_done;   end
            default: ;
        endcase
    end

    assign wdog_expired = in_stage && (wdog == TMO_LAST);
    assign last_image   = (image_idx == (img_count - IMG_ONE));
    assign state_dbg    = state;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    // abort beats everything; a stage done beats a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = (num_images == '0) ? S_DONE : S_CLEAR;
                S_CLEAR: state_nxt = S_CONV;
                S_CONV:  if (stage_done) state_nxt = S_POOL;
                         else if (wdog_expired) state_nxt = S_ERR;
                S_POOL:  if (stage_done) state_nxt = S_FC;
                         else if (wdog_expired) state_nxt = S_ERR;
                S_FC:    if (stage_done) state_nxt = last_image ? S_DONE : S_CLEAR;
                         else if (wdog_expired) state_nxt = S_ERR;
                S_DONE:  state_nxt = S_IDLE;
                S_ERR:   state_nxt = S_ERR;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    // Decoded from the next state and registered, so each output changes on
    // the same edge as the state it belongs to and never glitches.
    always_comb begin
        nxt_clear = (state_nxt == S_CLEAR);
        nxt_conv  = (state_nxt == S_CONV);
        nxt_pool  = (state_nxt == S_POOL);
        nxt_fc    = (state_nxt == S_FC);
        nxt_busy  = (state_nxt != S_IDLE);
        nxt_done  = (state_nxt == S_DONE);
        nxt_err   = (state_nxt == S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg.stage_clear <= 1'b0;
            stg.conv_enable <= 1'b0;
            stg.pool_enable <= 1'b0;
            stg.fc_enable   <= 1'b0;
            busy            <= 1'b0;
            seq_done        <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            stg.stage_clear <= nxt_clear;
            stg.conv_enable <= nxt_conv;
            stg.pool_enable <= nxt_pool;
            stg.fc_enable   <= nxt_fc;
            busy            <= nxt_busy;
            seq_done        <= nxt_done;
            timeout_err     <= nxt_err;
        end
    end

    // ------------------------------------------------------------- datapath
    // The watchdog restarts whenever a stage is entered (state changes) and
    // counts while the same stage persists. It cannot wrap: reaching the
    // last count either leaves the stage or traps in ERR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog      <= '0;
            image_idx <= '0;
            img_count <= '0;
        end else begin
            wdog <= (in_stage && (state_nxt == state)) ? (wdog + TMO_ONE) : '0;
            if (!abort) begin
                if ((state == S_IDLE) && start) begin
                    img_count <= num_images;
                    image_idx <= '0;
                end else if ((state == S_FC) && stg.fc_done && !last_image) begin
                    image_idx <= image_idx + IMG_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire
